// File: rtl/approx_add_pkg.sv
// Shared definitions for the approximate-adder scheduler.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package approx_add_pkg;

    localparam int W_DEF    = 16;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_t;

    // Bits needed to index n items (minimum 1 so that n=1 still yields a legal vector).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_add_sched_if.sv
// Bundle for the scheduler: requester side, result side, external adder side, status.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, res_valid/res_ready on results.
// Ports: slave = scheduler view, master = environment (requesters, consumer, adder).
interface approx_add_sched_if
    import approx_add_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = clog2(NREQ),
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic [W:0]        add_out;
    logic              res_valid;
    logic              res_ready;
    logic [W:0]        res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;
    logic [CNTW-1:0]   ops_done;

    modport master (
        output req_valid, req_a, req_b, res_ready, add_out,
        input  req_ready, add_in1, add_in2, res_valid, res_data, res_id, busy, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready, add_out,
        output req_ready, add_in1, add_in2, res_valid, res_data, res_id, busy, ops_done
    );

endinterface

// File: rtl/approx_add_sched_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used as a grant.
// Ports: req (request vector), ptr (search start), gnt (one-hot), idx (winner), any.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            // Only the first hit in search order wins.
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/approx_add_sched.sv
// Time-shares one external combinational W-bit adder among NREQ requesters, round-robin.
// Latency: grant edge to res_valid is 2 edges; one result per 2 cycles with res_ready high.
// Backpressure: a held result blocks new grants until res_ready; grant and release can share a cycle.
// Ports: clk, rst (async, active high), bus (slave modport: requests, result, adder, status).
module approx_add_sched
    import approx_add_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    approx_add_sched_if.slave bus
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [IDW-1:0]  op_id;
    logic            res_valid;
    logic [W:0]      res_data;
    logic [IDW-1:0]  res_id;
    logic [CNTW-1:0] ops_done;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            grant_ok;
    logic            do_grant;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A new operation may start when nothing is in flight, or when the held
    // result is being consumed in this very cycle. Reset masks the grant so
    // req_ready reads zero while rst is high.
    always_comb begin
        grant_ok  = (state == ST_IDLE) || ((state == ST_HOLD) && bus.res_ready);
        do_grant  = grant_ok && pick_any && !rst;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (do_grant) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    state_nxt = do_grant ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ops_done  <= '0;
        end else begin
            if (do_grant) begin
                op_a   <= bus.req_a[int'(pick_idx)*W +: W];
                op_b   <= bus.req_b[int'(pick_idx)*W +: W];
                op_id  <= pick_idx;
                rr_ptr <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
            end
            if (state == ST_EXEC) begin
                // Adder has had the whole EXEC cycle to settle on op_a/op_b.
                res_data  <= bus.add_out;
                res_id    <= op_id;
                res_valid <= 1'b1;
                if (ops_done != '1) begin
                    ops_done <= ops_done + 1'b1;
                end
            end else if ((state == ST_HOLD) && bus.res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = do_grant ? pick_gnt : '0;
    assign bus.add_in1   = op_a;
    assign bus.add_in2   = op_b;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_id    = res_id;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.ops_done  = ops_done;

endmodule

// File: tb/tb_approx_add_sched.sv
// Bench for approx_add_sched with an approximate lower-part-OR adder attached.
// Latency: n/a.
// Backpressure: consumer readiness driven directly and randomly.
module tb_approx_add_sched;
    import approx_add_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_add_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) bus ();

    approx_add_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Approximate adder: low 4 bits OR-ed, upper part exact with a carry guess from bit 3.
    function automatic logic [W:0] loa_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        r[3:0] = a[3:0] | b[3:0];
        r[W:4] = {1'b0, a[W-1:4]} + {1'b0, b[W-1:4]} + {{(W-4){1'b0}}, a[3] & b[3]};
        return r;
    endfunction

    assign bus.add_out = loa_add(bus.add_in1, bus.add_in2);

    int errors = 0;
    int checks = 0;

    // Transaction-level reference
    int         m_ptr;
    bit         m_exec;
    bit         m_hold;
    int         m_ops;
    logic [W-1:0] m_a, m_b;
    logic [W:0] q_data[$];
    int         q_id[$];
    int         glog[$];
    logic [W-1:0] a_v[NREQ];
    logic [W-1:0] b_v[NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr  = 0;
        m_exec = 1'b0;
        m_hold = 1'b0;
        m_ops  = 0;
        q_data.delete();
        q_id.delete();
    endtask

    // Asserts reset mid-cycle with all requests up, checks every output, releases after an edge.
    task automatic reset_pulse(input string tag);
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        rst = 1'b1;
        #1;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, ".add_in1"},   32'(bus.add_in1),   32'd0);
        check({tag, ".add_in2"},   32'(bus.add_in2),   32'd0);
        check({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, ".res_data"},  32'(bus.res_data),  32'd0);
        check({tag, ".res_id"},    32'(bus.res_id),    32'd0);
        check({tag, ".busy"},      32'(bus.busy),      32'd0);
        check({tag, ".ops_done"},  32'(bus.ops_done),  32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive, check against the reference, then advance both.
    task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input string tag);
        logic [NREQ-1:0] exp_gnt;
        int win;
        bus.req_valid = v;
        bus.res_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = a_v[i];
            bus.req_b[i*W +: W] = b_v[i];
        end
        #1;
        exp_gnt = '0;
        win = -1;
        if ((!m_exec && !m_hold) || (m_hold && rr)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) glog.push_back(i);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_gnt));
        check({tag, ".busy"},      32'(bus.busy),      32'(m_exec || m_hold));
        check({tag, ".res_valid"}, 32'(bus.res_valid), 32'(m_hold));
        check({tag, ".ops_done"},  32'(bus.ops_done),  32'(m_ops));
        if (m_hold) begin
            check({tag, ".res_data"}, 32'(bus.res_data), 32'(q_data[0]));
            check({tag, ".res_id"},   32'(bus.res_id),   32'(q_id[0]));
        end
        if (m_exec) begin
            check({tag, ".add_in1"}, 32'(bus.add_in1), 32'(m_a));
            check({tag, ".add_in2"}, 32'(bus.add_in2), 32'(m_b));
        end
        @(posedge clk);
        if (m_hold && rr) begin
            m_hold = 1'b0;
            void'(q_data.pop_front());
            void'(q_id.pop_front());
        end
        if (m_exec) begin
            m_exec = 1'b0;
            m_hold = 1'b1;
            if (m_ops != 65535) m_ops++;
        end
        if (win >= 0) begin
            m_exec = 1'b1;
            m_a = a_v[win];
            m_b = b_v[win];
            q_data.push_back(loa_add(a_v[win], b_v[win]));
            q_id.push_back(win);
            m_ptr = (win + 1) % NREQ;
            a_v[win] = W'($urandom);
            b_v[win] = W'($urandom);
        end
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = W'($urandom);
            b_v[i] = W'($urandom);
        end

        // Power-on reset, then idle with no requests
        reset_pulse("rst0");
        cycle('0, 1'b0, "idle0");
        cycle('0, 1'b0, "idle1");

        // Single operation from requester 0
        a_v[0] = 16'h0100;
        b_v[0] = 16'h0200;
        cycle(4'b0001, 1'b0, "op0_grant");
        cycle(4'b0000, 1'b0, "op0_exec");
        check("op0.res_valid", 32'(bus.res_valid), 32'd1);
        check("op0.res_data",  32'(bus.res_data),  32'h00300);
        check("op0.res_id",    32'(bus.res_id),    32'd0);
        check("op0.ops_done",  32'(bus.ops_done),  32'd1);
        cycle(4'b0000, 1'b0, "op0_hold");

        // Asynchronous reset while a result is held
        reset_pulse("rst_hold");

        // Carry out of the top operand bit lands in bit 16
        a_v[2] = 16'hFFC0;
        b_v[2] = 16'h0040;
        cycle(4'b0100, 1'b1, "carry_grant");
        cycle(4'b0000, 1'b1, "carry_exec");
        check("carry.res_data", 32'(bus.res_data), 32'h10000);
        check("carry.res_id",   32'(bus.res_id),   32'd2);
        cycle(4'b0000, 1'b1, "carry_release");
        cycle(4'b0000, 1'b1, "carry_idle");

        // Round-robin fairness with everyone requesting, consumer always ready
        reset_pulse("rst_rr");
        glog.delete();
        for (int i = 0; i < 10; i++) cycle('1, 1'b1, "rr");
        check("rr.grant_count", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            check("rr.grant0", 32'(glog[0]), 32'd0);
            check("rr.grant1", 32'(glog[1]), 32'd1);
            check("rr.grant2", 32'(glog[2]), 32'd2);
            check("rr.grant3", 32'(glog[3]), 32'd3);
            check("rr.grant4", 32'(glog[4]), 32'd0);
        end

        // Backpressure: result held five cycles while requester 1 waits
        for (int i = 0; i < 5; i++) cycle(4'b0010, 1'b0, "bp_hold");
        glog.delete();
        cycle(4'b0010, 1'b1, "bp_release");
        check("bp.grant_count", 32'(glog.size()), 32'd1);
        check("bp.res_valid",   32'(bus.res_valid), 32'd0);
        check("bp.busy",        32'(bus.busy),      32'd1);

        // Reset during EXEC drops the operation and rewinds the pointer
        reset_pulse("rst_exec");
        for (int i = 0; i < 3; i++) cycle('0, 1'b1, "post_rst");
        check("post_rst.ops_done", 32'(bus.ops_done), 32'd0);
        glog.delete();
        cycle(4'b1010, 1'b1, "post_rst_grant");
        check("post_rst.grant_count", 32'(glog.size()), 32'd1);
        if (glog.size() == 1) check("post_rst.grant_id", 32'(glog[0]), 32'd1);

        // Randomized traffic and consumer readiness
        for (int i = 0; i < 300; i++) begin
            cycle(NREQ'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
